decode_stage: RTL and testbench

- Instruction decode stage (ID) with the ID/EX pipeline register.
- Accepts 9-bit instructions from fetch through a valid/ready handshake and decodes the 5-bit opcode into a 9-bit control word, a 3-bit ALU op, register indices and an immediate.
- Registers the result for execute.
- Inserts a bubble on load-use hazards, drops work on a branch flush, and counts inserted bubbles.

---
 rtl/decode_stage.sv | 205 ++++++++++++++++++++
 tb/tb_decode_stage.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Instruction decode stage (ID) with the ID/EX pipeline register.
// Decodes 9-bit instructions into a control word, ALU op, register indices and
// an immediate. It stalls on a load-use hazard, drops work on a branch flush and
// counts inserted load-use bubbles.
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   in_valid/in_ready      fetch handshake; in_ready is combinational
//   in_instr, in_pc        instruction {opcode[8:4], rd[3:2], rs[1:0]} and its PC
//   flush                  kill the held and the incoming instruction
//   out_valid/out_ready    execute handshake on the ID/EX register
//   out_ctrl, out_alu_op   decoded control word and ALU operation
//   out_rd, out_rs         register indices
//   out_imm, out_pc        decoded immediate and PC of the held instruction
//   bubble_cnt             saturating count of load-use bubbles
module decode_stage #(
  parameter int unsigned DW  = 8,
  parameter int unsigned PCW = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [8:0]     in_instr,
  input  logic [PCW-1:0] in_pc,
  input  logic           flush,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [8:0]     out_ctrl,
  output logic [2:0]     out_alu_op,
  output logic [1:0]     out_rd,
  output logic [1:0]     out_rs,
  output logic [DW-1:0]  out_imm,
  output logic [PCW-1:0] out_pc,
  output logic [15:0]    bubble_cnt
);

  localparam int unsigned CW  = 9;
  localparam int unsigned AW  = 3;
  localparam int unsigned RW  = 2;
  localparam int unsigned BCW = 16;

  localparam logic [AW-1:0] ALU_ADD  = 3'b000;
  localparam logic [AW-1:0] ALU_SUB  = 3'b001;
  localparam logic [AW-1:0] ALU_SHR  = 3'b010;
  localparam logic [AW-1:0] ALU_SHL  = 3'b011;
  localparam logic [AW-1:0] ALU_AND  = 3'b100;
  localparam logic [AW-1:0] ALU_OR   = 3'b101;
  localparam logic [AW-1:0] ALU_XOR  = 3'b110;
  localparam logic [AW-1:0] ALU_PASS = 3'b111;

  // Control words: [8] bnez [7] beqz [6] jump [5] reg_write [4] mem_to_reg
  // [3] alu_src_imm [2] reserved [1] mem_read [0] mem_write
  localparam logic [CW-1:0] C_RR    = 9'b000100000;
  localparam logic [CW-1:0] C_RI    = 9'b000101000;
  localparam logic [CW-1:0] C_BEQZ  = 9'b010000000;
  localparam logic [CW-1:0] C_BNEZ  = 9'b100000000;
  localparam logic [CW-1:0] C_JUMP  = 9'b001000000;
  localparam logic [CW-1:0] C_LOAD  = 9'b000110010;
  localparam logic [CW-1:0] C_STORE = 9'b000000001;

  typedef enum logic [1:0] {
    IMM_ZERO = 2'd0,
    IMM_ZEXT = 2'd1,
    IMM_SEXT = 2'd2
  } imm_kind_e;

  logic [4:0]    opc;
  logic [CW-1:0] dec_ctrl;
  logic [AW-1:0] dec_op;
  logic          reads_rd;
  logic          reads_rs;
  imm_kind_e     imm_kind;
  logic [DW-1:0] dec_imm;

  logic           alive_q;
  logic           valid_q, valid_d;
  logic [CW-1:0]  ctrl_q, ctrl_d;
  logic [AW-1:0]  op_q, op_d;
  logic [RW-1:0]  rd_q, rd_d;
  logic [RW-1:0]  rs_q, rs_d;
  logic [DW-1:0]  imm_q, imm_d;
  logic [PCW-1:0] pc_q, pc_d;
  logic [BCW-1:0] bubble_cnt_q, bubble_cnt_d;

  logic hazard_c;
  logic in_ready_c;
  logic xfer_c;

  assign opc = in_instr[8:4];

  // Opcode decode: control word, ALU op, source-register usage, immediate class
  always_comb begin
    dec_ctrl = '0;
    dec_op   = ALU_PASS;
    reads_rd = 1'b0;
    reads_rs = 1'b0;
    imm_kind = IMM_ZERO;
    casez (opc)
      5'b00000: begin dec_ctrl = C_RR;    dec_op = ALU_ADD; reads_rd = 1'b1; reads_rs = 1'b1; end
      5'b00001: begin dec_ctrl = C_RR;    dec_op = ALU_SUB; reads_rd = 1'b1; reads_rs = 1'b1; end
      5'b0001?: begin dec_ctrl = C_RI;    dec_op = ALU_ADD; reads_rd = 1'b1; imm_kind = IMM_ZEXT; end
      5'b0010?: begin dec_ctrl = C_RI;    dec_op = ALU_SUB; reads_rd = 1'b1; imm_kind = IMM_ZEXT; end
      5'b0011?: begin dec_ctrl = C_RI;    dec_op = ALU_SHR; reads_rd = 1'b1; imm_kind = IMM_ZEXT; end
      5'b0100?: begin dec_ctrl = C_RI;    dec_op = ALU_SHL; reads_rd = 1'b1; imm_kind = IMM_ZEXT; end
      5'b01010: begin dec_ctrl = C_RR;    dec_op = ALU_AND; reads_rd = 1'b1; reads_rs = 1'b1; end
      5'b01011: begin dec_ctrl = C_RR;    dec_op = ALU_OR;  reads_rd = 1'b1; reads_rs = 1'b1; end
      5'b0110?: begin dec_ctrl = C_RI;    dec_op = ALU_AND; reads_rd = 1'b1; imm_kind = IMM_ZEXT; end
      5'b0111?: begin dec_ctrl = C_RR;    dec_op = ALU_XOR; reads_rd = 1'b1; reads_rs = 1'b1; end
      5'b1000?: begin dec_ctrl = C_BEQZ;  reads_rd = 1'b1; imm_kind = IMM_SEXT; end
      5'b1001?: begin dec_ctrl = C_BNEZ;  reads_rd = 1'b1; imm_kind = IMM_SEXT; end
      5'b1010?: begin dec_ctrl = C_JUMP;  imm_kind = IMM_SEXT; end
      5'b10110: begin dec_ctrl = C_LOAD;  reads_rs = 1'b1; end
      5'b10111: begin dec_ctrl = C_STORE; reads_rd = 1'b1; reads_rs = 1'b1; end
      5'b1100?: begin dec_ctrl = C_RR;    reads_rs = 1'b1; end
      5'b1101?: begin dec_ctrl = C_JUMP;  imm_kind = IMM_SEXT; end
      5'b1110?: begin dec_ctrl = C_JUMP;  end
      5'b1111?: begin dec_ctrl = C_RR;    dec_op = ALU_SHL; reads_rd = 1'b1; reads_rs = 1'b1; end
      default: ;
    endcase
  end

  // Immediate extension; ALU-immediate ops borrow opcode bit 0 as the imm MSB
  always_comb begin
    dec_imm = '0;
    case (imm_kind)
      IMM_ZEXT: dec_imm = DW'({in_instr[4], in_instr[1:0]});
      IMM_SEXT: dec_imm = DW'($signed(in_instr[4:0]));
      default:  dec_imm = '0;
    endcase
  end

  // Load-use hazard: held LOAD writes a register the incoming instruction reads
  assign hazard_c = valid_q && ctrl_q[1] && in_valid &&
                    ((reads_rd && (in_instr[3:2] == rd_q)) ||
                     (reads_rs && (in_instr[1:0] == rd_q)));

  // alive_q keeps in_ready low until the first edge after reset release
  assign in_ready_c = alive_q && !flush && !hazard_c && (!valid_q || out_ready);
  assign xfer_c     = in_valid && in_ready_c;

  // ID/EX register next state; flush beats transfer, transfer beats drain
  always_comb begin
    valid_d      = valid_q;
    ctrl_d       = ctrl_q;
    op_d         = op_q;
    rd_d         = rd_q;
    rs_d         = rs_q;
    imm_d        = imm_q;
    pc_d         = pc_q;
    bubble_cnt_d = bubble_cnt_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (xfer_c) begin
      valid_d = 1'b1;
      ctrl_d  = dec_ctrl;
      op_d    = dec_op;
      rd_d    = in_instr[3:2];
      rs_d    = in_instr[1:0];
      imm_d   = dec_imm;
      pc_d    = in_pc;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
    if (hazard_c && out_ready && !flush && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + BCW'(1);
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alive_q      <= 1'b0;
      valid_q      <= 1'b0;
      ctrl_q       <= '0;
      op_q         <= ALU_PASS;
      rd_q         <= '0;
      rs_q         <= '0;
      imm_q        <= '0;
      pc_q         <= '0;
      bubble_cnt_q <= '0;
    end else begin
      alive_q      <= 1'b1;
      valid_q      <= valid_d;
      ctrl_q       <= ctrl_d;
      op_q         <= op_d;
      rd_q         <= rd_d;
      rs_q         <= rs_d;
      imm_q        <= imm_d;
      pc_q         <= pc_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign in_ready   = in_ready_c;
  assign out_valid  = valid_q;
  assign out_ctrl   = ctrl_q;
  assign out_alu_op = op_q;
  assign out_rd     = rd_q;
  assign out_rs     = rs_q;
  assign out_imm    = imm_q;
  assign out_pc     = pc_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: table-driven decode vectors through a
// scoreboard, plus hand-written hazard, backpressure, flush, reset and
// saturation sequences.
module tb_decode_stage;

  localparam int unsigned DW  = 8;
  localparam int unsigned PCW = 8;

  logic           clk;
  logic           reset_n;
  logic           in_valid;
  logic           in_ready;
  logic [8:0]     in_instr;
  logic [PCW-1:0] in_pc;
  logic           flush;
  logic           out_valid;
  logic           out_ready;
  logic [8:0]     out_ctrl;
  logic [2:0]     out_alu_op;
  logic [1:0]     out_rd;
  logic [1:0]     out_rs;
  logic [DW-1:0]  out_imm;
  logic [PCW-1:0] out_pc;
  logic [15:0]    bubble_cnt;

  decode_stage #(.DW(DW), .PCW(PCW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_pc      (in_pc),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ctrl   (out_ctrl),
    .out_alu_op (out_alu_op),
    .out_rd     (out_rd),
    .out_rs     (out_rs),
    .out_imm    (out_imm),
    .out_pc     (out_pc),
    .bubble_cnt (bubble_cnt)
  );

  typedef struct packed {
    logic [8:0] instr;
    logic [7:0] pc;
    logic [8:0] ctrl;
    logic [2:0] op;
    logic [7:0] imm;
  } vec_t;

  typedef struct packed {
    logic [8:0] ctrl;
    logic [2:0] op;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [7:0] imm;
    logic [7:0] pc;
  } exp_t;

  exp_t        sb[$];
  int          checks;
  int          errors;
  bit          mon_en;
  logic [15:0] exp_bub;
  vec_t        vecs[21];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input vec_t v);
    exp_t e;
    e.ctrl = v.ctrl;
    e.op   = v.op;
    e.rd   = v.instr[3:2];
    e.rs   = v.instr[1:0];
    e.imm  = v.imm;
    e.pc   = v.pc;
    return e;
  endfunction

  function automatic vec_t at(input vec_t v, input logic [7:0] pc);
    vec_t r;
    r    = v;
    r.pc = pc;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction; push its expectation on the cycle it is accepted
  task automatic send(input vec_t v);
    bit done;
    done     = 1'b0;
    in_instr = v.instr;
    in_pc    = v.pc;
    in_valid = 1'b1;
    for (int t = 0; t < 20 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(mk(v));
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  // Monitor: every consumed ID/EX entry must match the scoreboard head
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && reset_n && out_valid && out_ready && !flush) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: pc %0h with empty scoreboard", out_pc);
      end else begin
        e = sb.pop_front();
        chk("out_ctrl",   32'(out_ctrl),   32'(e.ctrl));
        chk("out_alu_op", 32'(out_alu_op), 32'(e.op));
        chk("out_rd",     32'(out_rd),     32'(e.rd));
        chk("out_rs",     32'(out_rs),     32'(e.rs));
        chk("out_imm",    32'(out_imm),    32'(e.imm));
        chk("out_pc",     32'(out_pc),     32'(e.pc));
      end
    end
  end

  initial begin
    vec_t ld_c, add_c, add_ab, addi, subr, ld_cc;

    checks   = 0;
    errors   = 0;
    mon_en   = 1'b0;
    exp_bub  = 16'd0;
    reset_n  = 1'b0;
    in_valid = 1'b1;
    in_instr = 9'b00000_00_01;
    in_pc    = 8'h00;
    flush    = 1'b0;
    out_ready = 1'b1;

    //             instr          pc     ctrl          op      imm
    vecs[0]  = '{9'b00001_01_10, 8'h05, 9'b000100000, 3'b001, 8'h00}; // SUBR
    vecs[1]  = '{9'b00011_10_11, 8'h10, 9'b000101000, 3'b000, 8'h07}; // ADDI
    vecs[2]  = '{9'b10101_11_00, 8'h11, 9'b001000000, 3'b111, 8'hFC}; // J
    vecs[3]  = '{9'b00000_00_01, 8'h12, 9'b000100000, 3'b000, 8'h00}; // ADDR
    vecs[4]  = '{9'b00100_01_01, 8'h13, 9'b000101000, 3'b001, 8'h01}; // SUBI
    vecs[5]  = '{9'b00111_11_10, 8'h14, 9'b000101000, 3'b010, 8'h06}; // SHR
    vecs[6]  = '{9'b01000_00_11, 8'h15, 9'b000101000, 3'b011, 8'h03}; // SHL
    vecs[7]  = '{9'b01010_01_00, 8'h16, 9'b000100000, 3'b100, 8'h00}; // AND
    vecs[8]  = '{9'b01011_10_01, 8'h17, 9'b000100000, 3'b101, 8'h00}; // OR
    vecs[9]  = '{9'b01101_00_00, 8'h18, 9'b000101000, 3'b100, 8'h04}; // ANDI
    vecs[10] = '{9'b01110_11_11, 8'h19, 9'b000100000, 3'b110, 8'h00}; // XOR
    vecs[11] = '{9'b10000_01_11, 8'h1A, 9'b010000000, 3'b111, 8'h07}; // BEQZ
    vecs[12] = '{9'b10011_10_10, 8'h1B, 9'b100000000, 3'b111, 8'hFA}; // BNEQZ
    vecs[13] = '{9'b10110_00_11, 8'h1C, 9'b000110010, 3'b111, 8'h00}; // LOAD
    vecs[14] = '{9'b10111_01_10, 8'h1D, 9'b000000001, 3'b111, 8'h00}; // STORE
    vecs[15] = '{9'b11000_11_01, 8'h1E, 9'b000100000, 3'b111, 8'h00}; // MOV
    vecs[16] = '{9'b11011_00_01, 8'h1F, 9'b001000000, 3'b111, 8'hF1}; // CALL
    vecs[17] = '{9'b11100_10_11, 8'h20, 9'b001000000, 3'b111, 8'h00}; // RET
    vecs[18] = '{9'b11111_01_00, 8'h21, 9'b000100000, 3'b011, 8'h00}; // RSHL
    vecs[19] = '{9'b01111_00_10, 8'h22, 9'b000100000, 3'b110, 8'h00}; // XOR
    vecs[20] = '{9'b10100_00_00, 8'h23, 9'b001000000, 3'b111, 8'h00}; // J

    ld_c   = '{9'b10110_10_00, 8'h40, 9'b000110010, 3'b111, 8'h00};
    add_c  = '{9'b00000_10_00, 8'h41, 9'b000100000, 3'b000, 8'h00};
    add_ab = '{9'b00000_00_01, 8'h51, 9'b000100000, 3'b000, 8'h00};
    ld_cc  = '{9'b10110_10_10, 8'h00, 9'b000110010, 3'b111, 8'h00};
    addi   = at(vecs[1], 8'h60);
    subr   = at(vecs[0], 8'h61);

    // Reset values, with fetch offering an instruction
    #12;
    chk("rst_in_ready",   32'(in_ready),   32'd0);
    chk("rst_out_valid",  32'(out_valid),  32'd0);
    chk("rst_out_ctrl",   32'(out_ctrl),   32'd0);
    chk("rst_out_alu_op", 32'(out_alu_op), 32'd7);
    chk("rst_out_rd_rs",  32'({out_rd, out_rs}), 32'd0);
    chk("rst_out_imm",    32'(out_imm),    32'd0);
    chk("rst_out_pc",     32'(out_pc),     32'd0);
    chk("rst_bubble_cnt", 32'(bubble_cnt), 32'd0);
    in_valid = 1'b0;
    #5 reset_n = 1'b1;
    step();
    chk("ready_after_reset", 32'(in_ready), 32'd1);

    // Decode table streamed back to back
    mon_en = 1'b1;
    foreach (vecs[i]) send(vecs[i]);
    in_valid = 1'b0;
    step();
    step();
    chk("stream_drained", 32'(sb.size()), 32'd0);
    chk("stream_idle", 32'(out_valid), 32'd0);

    // Load-use: LOAD C then ADDR reading C
    in_instr = ld_c.instr; in_pc = ld_c.pc; in_valid = 1'b1;
    @(negedge clk);
    chk("ld_accept", 32'(in_ready), 32'd1);
    sb.push_back(mk(ld_c));
    step();
    in_instr = add_c.instr; in_pc = add_c.pc;
    @(negedge clk);
    chk("hz_in_ready", 32'(in_ready), 32'd0);
    chk("hz_ld_valid", 32'(out_valid), 32'd1);
    step();
    exp_bub = exp_bub + 16'd1;
    @(negedge clk);
    chk("hz_bubble_valid", 32'(out_valid), 32'd0);
    chk("hz_bubble_ready", 32'(in_ready), 32'd1);
    sb.push_back(mk(add_c));
    step();
    in_valid = 1'b0;
    chk("hz_addr_valid", 32'(out_valid), 32'd1);
    chk("hz_bubble_cnt", 32'(bubble_cnt), 32'(exp_bub));
    step();
    chk("hz_drained", 32'(out_valid), 32'd0);

    // LOAD C then ADDR reading A,B: no bubble
    in_instr = ld_c.instr; in_pc = 8'h50; in_valid = 1'b1;
    @(negedge clk);
    chk("nohz_ld_accept", 32'(in_ready), 32'd1);
    sb.push_back(mk(at(ld_c, 8'h50)));
    step();
    in_instr = add_ab.instr; in_pc = add_ab.pc;
    @(negedge clk);
    chk("nohz_in_ready", 32'(in_ready), 32'd1);
    sb.push_back(mk(add_ab));
    step();
    in_valid = 1'b0;
    chk("nohz_valid", 32'(out_valid), 32'd1);
    chk("nohz_bubble_cnt", 32'(bubble_cnt), 32'(exp_bub));
    step();
    step();

    // Backpressure: hold out_ready low for 3 cycles
    out_ready = 1'b0;
    in_instr = addi.instr; in_pc = addi.pc; in_valid = 1'b1;
    @(negedge clk);
    chk("bp_first_accept", 32'(in_ready), 32'd1);
    sb.push_back(mk(addi));
    step();
    in_instr = subr.instr; in_pc = subr.pc;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_ctrl", 32'(out_ctrl), 32'(addi.ctrl));
      chk("bp_hold_op_imm", 32'({out_alu_op, out_imm}), 32'({addi.op, addi.imm}));
      chk("bp_hold_rd_rs_pc", 32'({out_rd, out_rs, out_pc}), 32'({addi.instr[3:0], addi.pc}));
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    sb.push_back(mk(subr));
    step();
    in_valid = 1'b0;
    chk("bp_next_pc", 32'(out_pc), 32'h61);
    step();
    step();

    // Flush kills held and incoming
    out_ready = 1'b0;
    in_instr = vecs[3].instr; in_pc = 8'h70; in_valid = 1'b1;
    @(negedge clk);
    sb.push_back(mk(at(vecs[3], 8'h70)));
    step();
    in_instr = vecs[4].instr; in_pc = 8'h71;
    flush = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_kill", 32'(out_valid), 32'd0);
    sb.delete();
    step();
    step();
    chk("flush_dropped", 32'(out_valid), 32'd0);

    // Flush coincident with a load-use hazard
    in_instr = ld_c.instr; in_pc = 8'h80; in_valid = 1'b1;
    @(negedge clk);
    sb.push_back(mk(at(ld_c, 8'h80)));
    step();
    in_instr = add_c.instr; in_pc = 8'h81;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_hz_ready", 32'(in_ready), 32'd0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_hz_bubble_cnt", 32'(bubble_cnt), 32'(exp_bub));
    chk("flush_hz_valid", 32'(out_valid), 32'd0);
    sb.delete();
    step();

    // Asynchronous reset in the middle of a stall
    out_ready = 1'b0;
    in_instr = addi.instr; in_pc = 8'h90; in_valid = 1'b1;
    @(negedge clk);
    sb.push_back(mk(at(addi, 8'h90)));
    step();
    in_instr = subr.instr; in_pc = 8'h91;
    step();
    #2 reset_n = 1'b0;
    #1;
    chk("arst_out_valid",  32'(out_valid),  32'd0);
    chk("arst_out_ctrl",   32'(out_ctrl),   32'd0);
    chk("arst_out_alu_op", 32'(out_alu_op), 32'd7);
    chk("arst_out_rd_rs",  32'({out_rd, out_rs}), 32'd0);
    chk("arst_out_imm",    32'(out_imm),    32'd0);
    chk("arst_out_pc",     32'(out_pc),     32'd0);
    chk("arst_bubble_cnt", 32'(bubble_cnt), 32'd0);
    chk("arst_in_ready",   32'(in_ready),   32'd0);
    step();
    chk("arst_hold_valid", 32'(out_valid), 32'd0);
    #2 reset_n = 1'b1;
    sb.delete();
    exp_bub = 16'd0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    step();

    // Saturation: preload near the top, then drive repeated load-use hazards
    mon_en = 1'b0;
    force dut.bubble_cnt_q = 16'hFFFC;
    step();
    release dut.bubble_cnt_q;
    chk("sat_preload", 32'(bubble_cnt), 32'hFFFC);
    in_instr = ld_cc.instr; in_pc = 8'hA0; in_valid = 1'b1;
    for (int k = 0; k < 4; k++) step();
    chk("sat_partial", 32'(bubble_cnt), 32'hFFFE);
    for (int k = 0; k < 6; k++) step();
    chk("sat_hold", 32'(bubble_cnt), 32'hFFFF);
    in_valid = 1'b0;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
